window_motor_ctrl: RTL and testbench

Sequencing controller for a single power-window motor shared by two requesters: driver switch and passenger switch. Arbitrates open/close requests, drives clockwise (open) and counter-clockwise (close) motor enables, stops on end-of-travel limit switches, and enforces a motor-off dead time after every stop. A run timeout latches a fault. Sits between the debounced switch inputs and the motor H-bridge driver.

---
 rtl/window_pkg.sv | 38 +++
 rtl/window_req_arb.sv | 34 +++
 rtl/window_motor_ctrl.sv | 122 ++++++++++++
 tb/tb_window_motor_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types and defaults for the power-window motor controller.
package window_pkg;

  localparam int WINDOW_RUN_TIMEOUT = 1000;
  localparam int WINDOW_DEAD_TIME   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPENING = 3'd1,
    CLOSING = 3'd2,
    DEAD    = 3'd3,
    FAULT   = 3'd4
  } window_state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_OPEN  = 2'd1,
    CMD_CLOSE = 2'd2
  } window_cmd_t;

  typedef struct packed {
    logic cw;
    logic ccw;
    logic busy;
    logic fault;
  } window_out_t;

  // Output image of a state; registered alongside the state so outputs never glitch.
  function automatic window_out_t window_decode(input window_state_t s);
    window_out_t o;
    o.cw    = (s == OPENING);
    o.ccw   = (s == CLOSING);
    o.busy  = (s != IDLE);
    o.fault = (s == FAULT);
    return o;
  endfunction

endpackage

// File: rtl/window_req_arb.sv
// Resolves driver and passenger switch levels into a single open/close command.
module window_req_arb
  import window_pkg::*;
(
  input  logic        drv_open_req,
  input  logic        drv_close_req,
  input  logic        pass_open_req,
  input  logic        pass_close_req,
  input  logic        lock_pass,
  output window_cmd_t cmd
);

  window_cmd_t drv_cmd;
  window_cmd_t pass_cmd;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    drv_cmd  = CMD_NONE;
    pass_cmd = CMD_NONE;
    cmd      = CMD_NONE;

    if (drv_open_req && !drv_close_req)      drv_cmd = CMD_OPEN;
    else if (drv_close_req && !drv_open_req) drv_cmd = CMD_CLOSE;

    if (!lock_pass) begin
      if (pass_open_req && !pass_close_req)      pass_cmd = CMD_OPEN;
      else if (pass_close_req && !pass_open_req) pass_cmd = CMD_CLOSE;
    end

    // Driver wins outright; a losing passenger request is simply dropped.
    cmd = (drv_cmd != CMD_NONE) ? drv_cmd : pass_cmd;
  end

endmodule

// File: rtl/window_motor_ctrl.sv
// Power-window motor sequencer: arbitration, limit stop, run timeout fault, post-stop dead time.
module window_motor_ctrl
  import window_pkg::*;
#(
  parameter int RUN_TIMEOUT = WINDOW_RUN_TIMEOUT,
  parameter int DEAD_TIME   = WINDOW_DEAD_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic drv_open_req,
  input  logic drv_close_req,
  input  logic pass_open_req,
  input  logic pass_close_req,
  input  logic lock_pass,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic clear_fault,
  output logic motor_cw,
  output logic motor_ccw,
  output logic busy,
  output logic fault
);

  localparam int CNT_TOP = (RUN_TIMEOUT > DEAD_TIME) ? RUN_TIMEOUT : DEAD_TIME;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  window_cmd_t      cmd;
  window_state_t    state;
  logic [CNT_W-1:0] cnt;
  window_out_t      outs;
  logic             stop_hit;

  window_req_arb u_arb (
    .drv_open_req   (drv_open_req),
    .drv_close_req  (drv_close_req),
    .pass_open_req  (pass_open_req),
    .pass_close_req (pass_close_req),
    .lock_pass      (lock_pass),
    .cmd            (cmd)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Matching limit or any resolved press ends a run; the opposite limit is ignored.
  assign stop_hit = (state == OPENING && limit_open) ||
                    (state == CLOSING && limit_closed) ||
                    (cmd != CMD_NONE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      outs  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd == CMD_OPEN && !limit_open) begin
            state <= OPENING;
            outs  <= window_decode(OPENING);
          end else if (cmd == CMD_CLOSE && !limit_closed) begin
            state <= CLOSING;
            outs  <= window_decode(CLOSING);
          end
        end

        OPENING, CLOSING: begin
          if (stop_hit) begin
            state <= DEAD;
            cnt   <= '0;
            outs  <= window_decode(DEAD);
          end else if (cnt == RUN_LAST) begin
            state <= FAULT;
            cnt   <= '0;
            outs  <= window_decode(FAULT);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        DEAD: begin
          if (cnt == DEAD_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            outs  <= window_decode(IDLE);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        FAULT: begin
          cnt <= '0;
          // Leaving a fault still passes through the dead time.
          if (clear_fault) begin
            state <= DEAD;
            outs  <= window_decode(DEAD);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          outs  <= window_decode(IDLE);
        end
      endcase
    end
  end

  assign motor_cw  = outs.cw;
  assign motor_ccw = outs.ccw;
  assign busy      = outs.busy;
  assign fault     = outs.fault;

endmodule

// File: tb/tb_window_motor_ctrl.sv
// Directed bench for window_motor_ctrl: arbitration table plus run/stop/timeout sequences.
module tb_window_motor_ctrl;

  localparam int RT = 100;
  localparam int DT = 4;

  logic clk = 1'b0;
  logic reset;
  logic drv_open_req, drv_close_req, pass_open_req, pass_close_req;
  logic lock_pass, limit_open, limit_closed, clear_fault;
  logic motor_cw, motor_ccw, busy, fault;

  int total = 0;
  int bad   = 0;

  window_motor_ctrl #(.RUN_TIMEOUT(RT), .DEAD_TIME(DT)) dut (
    .clk            (clk),
    .reset          (reset),
    .drv_open_req   (drv_open_req),
    .drv_close_req  (drv_close_req),
    .pass_open_req  (pass_open_req),
    .pass_close_req (pass_close_req),
    .lock_pass      (lock_pass),
    .limit_open     (limit_open),
    .limit_closed   (limit_closed),
    .clear_fault    (clear_fault),
    .motor_cw       (motor_cw),
    .motor_ccw      (motor_ccw),
    .busy           (busy),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic d_o, d_c, p_o, p_c, lock, lim_o, lim_c;
    logic cw, ccw;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    drv_open_req   = 1'b0;
    drv_close_req  = 1'b0;
    pass_open_req  = 1'b0;
    pass_close_req = 1'b0;
    lock_pass      = 1'b0;
    limit_open     = 1'b0;
    limit_closed   = 1'b0;
    clear_fault    = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int on_cycles;

    //                d_o d_c p_o p_c lck lmo lmc  cw ccw
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0};

    // Reset held two cycles with requests active.
    clear_inputs();
    reset = 1'b1;
    drv_open_req   = 1'b1;
    pass_close_req = 1'b1;
    step();
    check("reset_c1_cw", motor_cw, 0);
    check("reset_c1_busy", busy, 0);
    step();
    check("reset_c2_ccw", motor_ccw, 0);
    check("reset_c2_fault", fault, 0);
    reset = 1'b0;
    clear_inputs();
    step();
    check("post_reset_busy", busy, 0);
    check("post_reset_motor", {motor_cw, motor_ccw}, 0);

    // Single-cycle request resolution from IDLE.
    for (int i = 0; i < 14; i++) begin
      pulse_reset();
      drv_open_req   = vecs[i].d_o;
      drv_close_req  = vecs[i].d_c;
      pass_open_req  = vecs[i].p_o;
      pass_close_req = vecs[i].p_c;
      lock_pass      = vecs[i].lock;
      limit_open     = vecs[i].lim_o;
      limit_closed   = vecs[i].lim_c;
      step();
      check($sformatf("vec%0d_cw", i), motor_cw, vecs[i].cw);
      check($sformatf("vec%0d_ccw", i), motor_ccw, vecs[i].ccw);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].cw | vecs[i].ccw);
      clear_inputs();
    end

    // Open run stopped by limit_open 20 cycles after the request.
    pulse_reset();
    drv_open_req = 1'b1;
    step();
    drv_open_req = 1'b0;
    check("open_run_start", motor_cw, 1);
    limit_closed = 1'b1;
    for (int i = 0; i < 19; i++) step();
    check("open_run_opposite_limit_ignored", motor_cw, 1);
    limit_closed = 1'b0;
    limit_open   = 1'b1;
    step();
    check("open_run_limit_stop_cw", motor_cw, 0);
    check("open_run_limit_stop_busy", busy, 1);
    for (int i = 0; i < DT - 1; i++) step();
    check("open_run_dead_busy", busy, 1);
    step();
    check("open_run_idle", busy, 0);
    clear_inputs();

    // Stop-on-press, request during DEAD ignored, restart one cycle after IDLE.
    pulse_reset();
    pass_close_req = 1'b1;
    step();
    pass_close_req = 1'b0;
    check("press_start_ccw", motor_ccw, 1);
    for (int i = 0; i < 9; i++) step();
    pass_open_req = 1'b1;
    step();
    pass_open_req = 1'b0;
    check("press_stop_ccw", motor_ccw, 0);
    check("press_stop_cw", motor_cw, 0);
    on_cycles = 0;
    drv_open_req = 1'b1;
    step();
    drv_open_req = 1'b0;
    if (motor_cw || motor_ccw) on_cycles++;
    for (int i = 0; i < DT - 2; i++) begin
      step();
      if (motor_cw || motor_ccw) on_cycles++;
    end
    check("press_dead_busy", busy, 1);
    step();
    if (motor_cw || motor_ccw) on_cycles++;
    check("press_dead_no_motor", on_cycles, 0);
    check("press_back_idle", busy, 0);
    drv_open_req = 1'b1;
    step();
    drv_open_req = 1'b0;
    check("press_restart_cw", motor_cw, 1);
    clear_inputs();

    // Limit and opposite request together during OPENING: limit wins, DEAD.
    pulse_reset();
    drv_open_req = 1'b1;
    step();
    drv_open_req  = 1'b0;
    limit_open    = 1'b1;
    drv_close_req = 1'b1;
    step();
    check("limit_win_cw", motor_cw, 0);
    check("limit_win_ccw", motor_ccw, 0);
    check("limit_win_busy", busy, 1);
    clear_inputs();

    // Run timeout: motor on for exactly RT cycles, then fault latched.
    pulse_reset();
    drv_open_req = 1'b1;
    step();
    drv_open_req = 1'b0;
    on_cycles = motor_cw ? 1 : 0;
    for (int i = 0; i < 3 * RT && motor_cw; i++) begin
      step();
      if (motor_cw) on_cycles++;
    end
    check("timeout_on_cycles", on_cycles, RT);
    check("timeout_fault", fault, 1);
    drv_close_req = 1'b1;
    step();
    drv_close_req = 1'b0;
    step();
    check("fault_held", fault, 1);
    check("fault_motor_off", {motor_cw, motor_ccw}, 0);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("clear_fault_low", fault, 0);
    check("clear_fault_busy", busy, 1);
    for (int i = 0; i < DT - 1; i++) step();
    check("clear_dead_busy", busy, 1);
    step();
    check("clear_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
